ambient_light_conditioner: RTL and testbench
============================================

# ambient_light_conditioner

Front-end stage for the street light controller: accepts raw ambient-light samples from the ADC interface, averages them over a 4-sample window, and applies dark/bright thresholds with hysteresis and persistence filtering. Produces the clean `light_sensor` level (1 = night) that drives the controller's `light_sensor` input, so ADC noise, passing headlights and brief shadows never toggle the lamp.

## Interface
- `WIDTH`, 8: ADC sample width in bits.
- `DARK_TH`, 64: average at or below this value counts as dark.
- `BRIGHT_TH`, 128: average at or above this value counts as bright. Must satisfy DARK_TH < BRIGHT_TH.
- `HOLD`, 3: number of consecutive qualifying averages required to change state. Legal range 2..15.

- `clk_in`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `sample_valid`  input  1  one-cycle strobe marking `sample_data` as a new sample. May be high on back-to-back cycles.
- `sample_data`  input  WIDTH  raw ambient level; a small value means dark.
- `light_sensor`  output  1  filtered night indication (1 = night); connects to the controller's `light_sensor` input.
- `avg_level`  output  WIDTH  current 4-sample average.
- `avg_valid`  output  1  one-cycle pulse when `avg_level` has been updated by a sample and the window is full.

## Operation
- **Window**
  - 4-entry sample shift register plus a saturating fill counter (0..4).
  - Each sample with `sample_valid` shifts in and drops the oldest entry.
  - Sum is WIDTH+2 bits wide. `avg_level` = sum >> 2 (truncating), registered.
  - `avg_valid` pulses only when the fill counter is 4 after this sample, i.e. from the 4th sample after reset onward.
- **Qualifying averages**
  - Dark qualifier: avg_level <= DARK_TH.
  - Bright qualifier: avg_level >= BRIGHT_TH.
  - Values strictly between the thresholds qualify for neither.
- **State machine** (Moore; 4-bit persistence counter `cnt`). Evaluated only on cycles where `avg_valid` = 1; otherwise state and `cnt` hold.
  - DAY (`light_sensor` = 0): dark average → TO_NIGHT, cnt = 1.
  - TO_NIGHT (0):
    - Dark average → cnt + 1; if cnt + 1 == HOLD, go to NIGHT with cnt = 0.
    - Any other average → DAY, cnt = 0.
  - NIGHT (1): bright average → TO_DAY, cnt = 1.
  - TO_DAY (1):
    - Bright average → cnt + 1; if cnt + 1 == HOLD, go to DAY with cnt = 0.
    - Any other average → NIGHT, cnt = 0.
- `light_sensor` is decoded from the state register: 1 in NIGHT and TO_DAY, 0 in DAY and TO_NIGHT. No combinational path from any input.
- **Reset**
  - Asserted at any time, including mid-transition: samples = 0, fill = 0, state = DAY, cnt = 0.
  - Outputs: `light_sensor` = 0, `avg_level` = 0, `avg_valid` = 0.
  - After release the window must refill with 4 new samples before any decision is made.
- Gaps in `sample_valid` of any length have no effect on the filter.

## Timing
- Edge E0 captures a sample (`sample_valid` = 1). `avg_level` and `avg_valid` are visible after E0.
- The FSM consumes that average at E1. `light_sensor` reflects the new state after E1.
- Latency from sample capture to `light_sensor` change: 2 clock edges.
- Minimum time for `light_sensor` to change after reset: 4 + HOLD − 1 samples when the first average already qualifies.
- Back-to-back samples are fully pipelined; one decision per sample with no stalls.

## Test plan
Use defaults (DARK_TH = 64, BRIGHT_TH = 128, HOLD = 3).
1. **Reset/fill:** assert reset → all outputs 0. Release, send 3 samples of 0 → no `avg_valid`, `light_sensor` = 0. Send 4th sample → `avg_valid` pulse with `avg_level` = 0.
2. **Day→night:** after reset, send six samples of 20 → averages 20 at samples 4, 5, 6. `light_sensor` rises 2 edges after sample 6 is captured, not earlier.
3. **Glitch rejection:** after reset, send 40, 40, 40, 40, 40, 255 → averages 40, 40, 93. The 93 is non-qualifying, so the state returns to DAY and `light_sensor` stays 0 throughout.
4. **Night→day:** from NIGHT (window full of 20), send 255 × 4 → averages 78, 137, 196, 255. The 3rd consecutive bright average (255) returns to DAY; `light_sensor` falls 2 edges after the 4th 255 is captured.
5. **Hysteresis:** in NIGHT, send 20 samples of 100 → `avg_level` settles at 100 and `light_sensor` stays 1. Repeat in DAY → stays 0.
6. **Reset mid-operation:** in TO_DAY (`light_sensor` = 1), assert reset asynchronously between edges → `light_sensor`, `avg_valid` and `avg_level` go to 0 immediately. After release, 3 samples of 255 produce no `avg_valid`.

Source files
------------

// File: rtl/ambient_light_conditioner.sv
// ambient_light_conditioner: 4-sample moving average of raw ADC light samples,
// followed by a dark/bright hysteresis FSM with persistence filtering.
// Latency: sample capture -> avg_level/avg_valid 1 edge, -> light_sensor 2 edges.
// Backpressure: none; one sample per cycle is accepted and fully pipelined.
//
// Ports:
//   clk_in        rising-edge clock
//   reset         asynchronous, active-high; clears all state
//   sample_valid  one-cycle strobe qualifying sample_data
//   sample_data   raw ambient level (small = dark)
//   light_sensor  filtered night indication (1 = night), decoded from state only
//   avg_level     registered 4-sample average (truncated)
//   avg_valid     one-cycle pulse when avg_level was updated with a full window
module ambient_light_conditioner #(
  parameter int WIDTH     = 8,
  parameter int DARK_TH   = 64,
  parameter int BRIGHT_TH = 128,
  parameter int HOLD      = 3
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_data,
  output logic             light_sensor,
  output logic [WIDTH-1:0] avg_level,
  output logic             avg_valid
);

  localparam logic [WIDTH-1:0] DARK_LV   = WIDTH'(DARK_TH);
  localparam logic [WIDTH-1:0] BRIGHT_LV = WIDTH'(BRIGHT_TH);
  localparam logic [3:0]       HOLD_C    = 4'(HOLD);

  typedef enum logic [1:0] {
    DAY      = 2'd0,
    TO_NIGHT = 2'd1,
    NIGHT    = 2'd2,
    TO_DAY   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Averaging window.
  // The window is the incoming sample plus the three previous ones; the oldest
  // of the four would only ever be dropped, so it is not stored.
  // ---------------------------------------------------------------------------
  logic [2:0][WIDTH-1:0] hist;
  logic [2:0]            fill;
  logic [2:0]            fill_next;
  logic [WIDTH+1:0]      win_sum;

  always_comb begin
    win_sum   = {2'b00, sample_data} + {2'b00, hist[0]}
              + {2'b00, hist[1]}     + {2'b00, hist[2]};
    fill_next = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      hist      <= '0;
      fill      <= 3'd0;
      avg_level <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (sample_valid) begin
        hist[0]   <= sample_data;
        hist[1]   <= hist[0];
        hist[2]   <= hist[1];
        fill      <= fill_next;
        avg_level <= win_sum[WIDTH+1:2];
        // Decisions are only made once four real samples fill the window.
        avg_valid <= (fill_next == 3'd4);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hysteresis / persistence FSM. Only advances on a fresh full-window average.
  // ---------------------------------------------------------------------------
  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic [3:0] cnt_inc;
  logic       dark;
  logic       bright;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state <= DAY;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    dark       = (avg_level <= DARK_LV);
    bright     = (avg_level >= BRIGHT_LV);
    cnt_inc    = cnt + 4'd1;

    if (avg_valid) begin
      case (state)
        DAY: begin
          if (dark) begin
            state_next = TO_NIGHT;
            cnt_next   = 4'd1;
          end
        end
        TO_NIGHT: begin
          if (dark) begin
            if (cnt_inc == HOLD_C) begin
              state_next = NIGHT;
              cnt_next   = 4'd0;
            end else begin
              cnt_next   = cnt_inc;
            end
          end else begin
            // Any break in the dark run (including mid-band) restarts it.
            state_next = DAY;
            cnt_next   = 4'd0;
          end
        end
        NIGHT: begin
          if (bright) begin
            state_next = TO_DAY;
            cnt_next   = 4'd1;
          end
        end
        TO_DAY: begin
          if (bright) begin
            if (cnt_inc == HOLD_C) begin
              state_next = DAY;
              cnt_next   = 4'd0;
            end else begin
              cnt_next   = cnt_inc;
            end
          end else begin
            state_next = NIGHT;
            cnt_next   = 4'd0;
          end
        end
        default: begin
          state_next = DAY;
          cnt_next   = 4'd0;
        end
      endcase
    end
  end

  // Night is indicated while in NIGHT or while still confirming a return to day.
  assign light_sensor = (state == NIGHT) || (state == TO_DAY);

endmodule

// File: tb/tb_ambient_light_conditioner.sv
// tb_ambient_light_conditioner: directed test-plan sequences plus randomized
// samples, gaps and asynchronous resets, checked against a behavioural model
// (queue-based moving average and a run-length hysteresis rule).
module tb_ambient_light_conditioner;

  localparam int WIDTH     = 8;
  localparam int DARK_TH   = 64;
  localparam int BRIGHT_TH = 128;
  localparam int HOLD      = 3;

  logic             clk_in;
  logic             reset;
  logic             sample_valid;
  logic [WIDTH-1:0] sample_data;
  logic             light_sensor;
  logic [WIDTH-1:0] avg_level;
  logic             avg_valid;

  int tests;
  int fails;

  ambient_light_conditioner #(
    .WIDTH(WIDTH), .DARK_TH(DARK_TH), .BRIGHT_TH(BRIGHT_TH), .HOLD(HOLD)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .sample_valid(sample_valid),
    .sample_data(sample_data),
    .light_sensor(light_sensor),
    .avg_level(avg_level),
    .avg_valid(avg_valid)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  int q[$];      // most recent sample at index 0, always 4 entries
  int m_fill;    // number of real samples seen since reset (saturating)
  int m_avg;
  bit m_vld;
  bit m_night;
  int m_run;     // consecutive qualifying averages toward the opposite level

  task automatic model_reset();
    q = '{0, 0, 0, 0};
    m_fill  = 0;
    m_avg   = 0;
    m_vld   = 0;
    m_night = 0;
    m_run   = 0;
  endtask

  task automatic model_edge(input bit v, input int d);
    int s;
    // Decision uses the average that was visible before this edge.
    if (m_vld) begin
      bit qual;
      qual = m_night ? (m_avg >= BRIGHT_TH) : (m_avg <= DARK_TH);
      if (qual) m_run = m_run + 1;
      else      m_run = 0;
      if (m_run == HOLD) begin
        m_night = !m_night;
        m_run   = 0;
      end
    end
    if (v) begin
      q.push_front(d);
      void'(q.pop_back());
      if (m_fill < 4) m_fill = m_fill + 1;
      s = 0;
      foreach (q[i]) s = s + q[i];
      m_avg = s / 4;
      m_vld = (m_fill == 4);
    end else begin
      m_vld = 0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input int obs, input int exp);
    tests = tests + 1;
    if (obs !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("avg_valid", int'(avg_valid), int'(m_vld));
    chk("avg_level", int'(avg_level), m_avg);
    chk("light_sensor", int'(light_sensor), int'(m_night));
  endtask

  // Called at posedge+1: drive inputs, advance one edge, check at posedge+1.
  task automatic drive_cycle(input bit v, input int d);
    sample_valid = v;
    sample_data  = 8'(d);
    @(posedge clk_in);
    model_edge(v, d);
    #1;
    check_outputs();
  endtask

  task automatic send(input int n, input int d);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    sample_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_avg_valid", int'(avg_valid), 0);
    chk("rst_avg_level", int'(avg_level), 0);
    chk("rst_light", int'(light_sensor), 0);
    #2 reset = 1'b0;
  endtask

  initial begin
    int mode;
    int d;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    chk("init_avg_valid", int'(avg_valid), 0);
    chk("init_avg_level", int'(avg_level), 0);
    chk("init_light", int'(light_sensor), 0);
    #2 reset = 1'b0;
    @(posedge clk_in);
    #1;

    // 1. reset/fill
    send(3, 0);
    send(1, 0);
    chk("fill_4th_valid", int'(avg_valid), 1);
    idle(2);

    // 2. day -> night
    async_reset();
    send(6, 20);
    chk("night_not_yet", int'(light_sensor), 0);
    idle(1);
    chk("night_after_2", int'(light_sensor), 1);

    // 4. night -> day, with a gap in the middle
    send(2, 255);
    idle(3);
    send(2, 255);
    idle(1);
    chk("day_after_255s", int'(light_sensor), 0);

    // 3. glitch rejection
    async_reset();
    send(5, 40);
    send(1, 255);
    idle(2);
    chk("glitch_day", int'(light_sensor), 0);

    // 5. hysteresis in DAY and in NIGHT
    send(20, 100);
    chk("hyst_day", int'(light_sensor), 0);
    send(6, 10);
    idle(1);
    send(20, 100);
    chk("hyst_night", int'(light_sensor), 1);

    // 6. reset while in TO_DAY
    send(4, 10);
    idle(1);
    send(2, 255);
    idle(1);
    chk("to_day_light", int'(light_sensor), 1);
    async_reset();
    send(3, 255);
    idle(1);

    // Randomized phases of dark / bright / mid-band / near-threshold / noise
    for (int p = 0; p < 80; p++) begin
      mode = int'($urandom_range(0, 4));
      for (int c = 0; c < 25; c++) begin
        if ($urandom_range(0, 299) == 0) async_reset();
        case (mode)
          0:       d = int'($urandom_range(0, 64));
          1:       d = int'($urandom_range(128, 255));
          2:       d = int'($urandom_range(65, 127));
          3:       d = ($urandom_range(0, 1) != 0) ? int'($urandom_range(58, 70))
                                                   : int'($urandom_range(122, 134));
          default: d = int'($urandom_range(0, 255));
        endcase
        drive_cycle($urandom_range(0, 9) < 7, d);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
